// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, LSU state encoding, op legality helpers.
// Pure definitions, no logic or latency of its own.
// No backpressure concerns; consumed by load_store_unit and load_extend.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_t;

    // Stores only have signed widths; unsigned codes are loads-only.
    function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
        logic bad;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = store;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Bytes are never misaligned; halves need even, words need 4-byte alignment.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the LSU (master) and memory (slave).
// Request is level-held by the master until the slave returns mem_ready.
// Backpressure: slave inserts wait states simply by holding mem_ready low.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
// Purely combinational, zero latency.
// No backpressure; result is consumed by the LSU when mem_ready is high.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select by byte offset, then extend according to width/sign code.
    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one data-memory transaction per load/store, extended load data back to the pipe.
// Latency: start -> mem_req next cycle; mem_ready -> done next cycle; misaligned/illegal -> done next cycle.
// Backpressure: stall held while accepting and while waiting on mem_ready. Optional LSU_TIMEOUT_EN bus-error abort.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      is_store,
    input  logic [2:0]                funct3,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic                      stall,
    output logic                      done,
    output logic [31:0]               rdata,
    output logic                      err_misalign,
    output logic                      err_bus,
    load_store_unit_if.master         mem
);

    lsu_state_t  state;
    logic        op_store;
    logic [2:0]  op_f3;
    logic [1:0]  op_off;

    logic        op_reject;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] ext_data;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
    logic [CNT_W-1:0] wait_cnt;
`endif

    load_extend u_load_extend (
        .word   (mem.mem_rdata),
        .offset (op_off),
        .funct3 (op_f3),
        .data   (ext_data)
    );

    assign stall = ((state == LSU_IDLE) && start) || (state == LSU_REQ);

    // Decode the incoming op into lane enables and replicated store data.
    always_comb begin
        op_reject = f3_illegal(is_store, funct3) || f3_misaligned(funct3, addr[1:0]);
        case (funct3[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << addr[1:0];
                wdata_nxt = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_nxt    = 4'b0011 << addr[1:0];
                wdata_nxt = {2{wdata[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = wdata;
            end
        endcase
    end

    // Access FSM with registered bus and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= LSU_IDLE;
            op_store      <= 1'b0;
            op_f3         <= 3'b000;
            op_off        <= 2'b00;
            done          <= 1'b0;
            rdata         <= 32'h0;
            err_misalign  <= 1'b0;
            err_bus       <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'h0;
            mem.mem_be    <= 4'h0;
            mem.mem_wdata <= 32'h0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (start) begin
                        op_store <= is_store;
                        op_f3    <= funct3;
                        op_off   <= addr[1:0];
                        if (op_reject) begin
                            // Rejected ops never touch the bus.
                            state        <= LSU_RESP;
                            done         <= 1'b1;
                            rdata        <= 32'h0;
                            err_misalign <= 1'b1;
                            err_bus      <= 1'b0;
                        end else begin
                            state         <= LSU_REQ;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= is_store;
                            mem.mem_addr  <= {addr[31:2], 2'b00};
                            mem.mem_be    <= be_nxt;
                            mem.mem_wdata <= wdata_nxt;
`ifdef LSU_TIMEOUT_EN
                            wait_cnt      <= '0;
`endif
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem.mem_ready) begin
                        state        <= LSU_RESP;
                        mem.mem_req  <= 1'b0;
                        done         <= 1'b1;
                        rdata        <= op_store ? 32'h0 : ext_data;
                        err_misalign <= 1'b0;
                        err_bus      <= 1'b0;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Memory never answered: abandon the access.
                        state        <= LSU_RESP;
                        mem.mem_req  <= 1'b0;
                        done         <= 1'b1;
                        rdata        <= 32'h0;
                        err_misalign <= 1'b0;
                        err_bus      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                LSU_RESP: begin
                    state <= LSU_IDLE;
                end
                default: begin
                    state <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed + randomized bench for load_store_unit with a behavioural memory-access model.
// Drives and samples on the falling clock edge; memory wait states are chosen per access.
// Optional LSU_TIMEOUT_EN section exercises the bus-error abort at the default timeout.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err_misalign;
    logic        err_bus;

    int checks   = 0;
    int failures = 0;

    load_store_unit_if mif ();

    load_store_unit dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .is_store     (is_store),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .done         (done),
        .rdata        (rdata),
        .err_misalign (err_misalign),
        .err_bus      (err_bus),
        .mem          (mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: which ops must be refused without a bus access.
    function automatic bit ref_bad(input bit st, input bit [2:0] f3, input bit [31:0] a);
        if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
        if (st && f3 >= 3'd4) return 1'b1;
        if (f3[1:0] == 2'd1 && (a % 2) != 0) return 1'b1;
        if (f3[1:0] == 2'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int ref_size(input bit [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit [3:0] ref_be(input bit [2:0] f3, input bit [31:0] a);
        int m;
        m = ((1 << ref_size(f3)) - 1) << (a % 4);
        return 4'(m);
    endfunction

    function automatic bit [31:0] ref_wdata(input bit [2:0] f3, input bit [31:0] w);
        if (ref_size(f3) == 1) return 32'(w[7:0]) * 32'h0101_0101;
        if (ref_size(f3) == 2) return 32'(w[15:0]) * 32'h0001_0001;
        return w;
    endfunction

    function automatic bit [31:0] ref_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] word);
        bit [31:0] mask;
        bit [31:0] val;
        int        n;
        n    = ref_size(f3);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
        val  = (word >> (8 * (a % 4))) & mask;
        if (!f3[2] && n < 4 && val >= ((mask + 1) / 2)) val = val | ~mask;
        return val;
    endfunction

    // One complete access: present op, model memory with 'waits' wait states, check everything.
    task automatic access(input string tag, input bit st, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] wd, input int waits, input bit [31:0] word);
        bit        bad;
        bit [31:0] exp_rd;
        bad    = ref_bad(st, f3, a);
        exp_rd = st ? 32'h0 : ref_load(f3, a, word);
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        #1;
        chk({tag, " stall_on_start"}, 32'(stall), 32'd1);
        @(negedge clk);
        start = 1'($urandom_range(0, 1)); is_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; wdata = $urandom;
        #1;
        if (bad) begin
            chk({tag, " rej_done"}, 32'(done), 32'd1);
            chk({tag, " rej_err_misalign"}, 32'(err_misalign), 32'd1);
            chk({tag, " rej_err_bus"}, 32'(err_bus), 32'd0);
            chk({tag, " rej_no_req"}, 32'(mif.mem_req), 32'd0);
            chk({tag, " rej_stall"}, 32'(stall), 32'd0);
        end else begin
            for (int i = 0; i <= waits; i++) begin
                mif.mem_ready = (i == waits);
                mif.mem_rdata = (i == waits) ? word : $urandom;
                #1;
                chk({tag, " req"}, 32'(mif.mem_req), 32'd1);
                chk({tag, " we"}, 32'(mif.mem_we), 32'(st));
                chk({tag, " addr"}, mif.mem_addr, a & 32'hFFFF_FFFC);
                chk({tag, " be"}, 32'(mif.mem_be), 32'(ref_be(f3, a)));
                if (st) chk({tag, " wdata"}, mif.mem_wdata, ref_wdata(f3, wd));
                chk({tag, " stall_req"}, 32'(stall), 32'd1);
                chk({tag, " no_done_req"}, 32'(done), 32'd0);
                @(negedge clk);
                start = 1'($urandom_range(0, 1)); addr = $urandom; funct3 = 3'($urandom);
            end
            mif.mem_ready = 1'b0;
            mif.mem_rdata = $urandom;
            #1;
            chk({tag, " done"}, 32'(done), 32'd1);
            chk({tag, " req_dropped"}, 32'(mif.mem_req), 32'd0);
            chk({tag, " rdata"}, rdata, exp_rd);
            chk({tag, " err_misalign"}, 32'(err_misalign), 32'd0);
            chk({tag, " err_bus"}, 32'(err_bus), 32'd0);
            chk({tag, " stall_resp"}, 32'(stall), 32'd0);
        end
        // A start presented during RESP must be dropped.
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, " resp_start_ignored"}, 32'(mif.mem_req), 32'd0);
        if (!bad) chk({tag, " rdata_held"}, rdata, exp_rd);
        chk({tag, " err_held"}, 32'(err_misalign), 32'(bad));
    endtask

    initial begin
        int cycles;
        reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0;
        mif.mem_ready = 1'b0; mif.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_req", 32'(mif.mem_req), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_errs", {30'h0, err_misalign, err_bus}, 32'h0);
        reset = 1'b0;

        access("lw_basic",  1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
        access("lb_neg",    1'b0, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h8012_3456);
        access("lbu",       1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h8012_3456);
        access("lh_hi",     1'b0, 3'b001, 32'h0000_0202, 32'h0, 2, 32'hF00D_1234);
        access("sh_waits",  1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 32'h0);
        access("sb_lane1",  1'b1, 3'b000, 32'h0000_0301, 32'h0000_005A, 0, 32'h0);
        access("lw_mis",    1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 32'h0);
        access("f3_011",    1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0);
        access("sbu_illeg", 1'b1, 3'b100, 32'h0000_0100, 32'h0, 0, 32'h0);

        // Reset in the middle of a request.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("rst_mid_req_up", 32'(mif.mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_req", 32'(mif.mem_req), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        access("after_reset", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 1, 32'h0BAD_F00D);

        for (int n = 0; n < 60; n++) begin
            access("rand", 1'($urandom), 3'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, 4)), $urandom);
        end

`ifdef LSU_TIMEOUT_EN
        // Memory never answers: request must be abandoned after the default 16 cycles.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400;
        mif.mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        cycles = 0;
        while (mif.mem_req && cycles < 40) begin
            cycles++;
            @(negedge clk);
            #1;
        end
        chk("to_req_cycles", 32'(cycles), 32'd16);
        chk("to_done", 32'(done), 32'd1);
        chk("to_err_bus", 32'(err_bus), 32'd1);
        chk("to_rdata", rdata, 32'h0);
`else
        cycles = 0;
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
